// File: rtl/score_pkg.sv
// Shared parameters, FSM encoding and BCD helper
// for the score display controller.
package score_pkg;

  localparam int SCORE_W    = 14;
  localparam int INC_W      = 4;
  localparam int MAX_SCORE  = 9999;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(SCORE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [BCD_W-1:0] add3(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD engine.
// One shift per cycle, SCORE_W shift cycles per run.
module bin2bcd_seq
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin_in,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);

  state_t state, state_next;
  logic [BCD_W-1:0]         bcd_q;
  logic [SCORE_W-1:0]       bin_q;
  logic [CNT_W-1:0]         cnt;
  logic [BCD_W+SCORE_W-1:0] shifted;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);

  assign shifted = {add3(bcd_q), bin_q} << 1;
  assign bcd     = bcd_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Capture and shift datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      bcd_q <= '0;
      bin_q <= bin_in;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      {bcd_q, bin_q} <= shifted;
      cnt            <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score register, dirty tracking and display output.
// Optional high score via macro SCORE_HISCORE_EN.
module score_display_ctrl
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic [INC_W-1:0]   inc_amount,
  input  logic               clear,
  input  logic               show_hi,
  output logic [SCORE_W-1:0] score,
  output logic [15:0]        disp_value,
  output logic               busy,
  output logic               update_done
);

  localparam logic [SCORE_W:0] MAX_W = (SCORE_W + 1)'(MAX_SCORE);

  logic [SCORE_W-1:0] score_q, score_next;
  logic [SCORE_W:0]   sum;
  logic               dirty, changed, capture;
  logic [15:0]        disp_q;
  logic               eng_busy, eng_done;
  logic [BCD_W-1:0]   eng_bcd;

  assign sum     = {1'b0, score_q} + (SCORE_W + 1)'(inc_amount);
  assign changed = (score_next != score_q);
  assign capture = dirty && !eng_busy;

  // Saturating score update; clear has priority
  always_comb begin
    score_next = score_q;
    if (clear)
      score_next = '0;
    else if (inc)
      score_next = (sum > MAX_W) ? MAX_W[SCORE_W-1:0]
                                 : sum[SCORE_W-1:0];
  end

  // Score, dirty flag and display registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_q     <= '0;
      dirty       <= 1'b0;
      disp_q      <= '0;
      update_done <= 1'b0;
    end else begin
      score_q     <= score_next;
      dirty       <= changed || (dirty && !capture);
      update_done <= eng_done;
      if (eng_done) disp_q <= eng_bcd;
    end
  end

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (dirty),
    .bin_in (score_q),
    .busy   (eng_busy),
    .done   (eng_done),
    .bcd    (eng_bcd)
  );

  assign score = score_q;
  assign busy  = eng_busy;

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] hi_score, cap_score;
  logic [15:0]        hi_bcd;

  // Track the highest converted score
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_score  <= '0;
      hi_bcd    <= '0;
      cap_score <= '0;
    end else begin
      if (capture) cap_score <= score_q;
      if (eng_done && cap_score > hi_score) begin
        hi_score <= cap_score;
        hi_bcd   <= eng_bcd;
      end
    end
  end

  assign disp_value = show_hi ? hi_bcd : disp_q;
`else
  logic unused_show_hi;
  assign unused_show_hi = show_hi;
  assign disp_value     = disp_q;
`endif

endmodule
